// File: rtl/gam_edge_age_controller.sv
// gam_edge_age_controller: one GAM edge link/age/prune sweep per request over a single-port connection RAM.
// Define GAM_SYMMETRIC_EDGE_EN to mirror every write into the transposed entry [c][col][row].
module gam_edge_age_controller #(
   parameter int NODE_COUNT  = 10,
   parameter int CLASS_COUNT = 4,
   parameter int AGE_MAX     = 2,
   parameter int AGE_W       = 8,
   localparam int NW = $clog2(NODE_COUNT + 1),
   localparam int CW = $clog2(CLASS_COUNT + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CW-1:0]    req_class,
   input  logic [NW-1:0]    req_s1,
   input  logic [NW-1:0]    req_s2,
   output logic             mem_en,
   output logic             mem_we,
   output logic [CW-1:0]    mem_class,
   output logic [NW-1:0]    mem_row,
   output logic [NW-1:0]    mem_col,
   output logic             mem_wpresence,
   output logic [AGE_W-1:0] mem_wage,
   input  logic             mem_rpresence,
   input  logic [AGE_W-1:0] mem_rage,
   output logic             done,
   output logic             err,
   output logic [NW-1:0]    prune_count
);
`ifdef GAM_SYMMETRIC_EDGE_EN
   typedef enum logic [2:0] {IDLE, LINK, LINK2, RD, WAIT, WR, WR2, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LINK, RD, WAIT, WR, DONE} state_t;
`endif
   state_t           state_q, state_d;
   logic [CW-1:0]    cls_q, cls_d;
   logic [NW-1:0]    s1_q, s1_d, s2_q, s2_d, j_q, j_d, prune_q, prune_d;
   logic             pres_q, pres_d, err_q, err_d;
   logic [AGE_W-1:0] age_q, age_d, nage;
   logic             bad, upd, kill, last;

   assign bad = req_class == '0 || req_class > CW'(CLASS_COUNT) || req_s1 == '0 || req_s1 > NW'(NODE_COUNT)
             || req_s2 == '0 || req_s2 > NW'(NODE_COUNT) || req_s1 == req_s2;
   assign nage = &age_q ? age_q : age_q + 1'b1;
   assign kill = nage > AGE_W'(AGE_MAX);
   assign upd = pres_q && j_q != s1_q && j_q != s2_q;
   assign last = j_q == NW'(NODE_COUNT);
   assign req_ready = state_q == IDLE;
   assign done = state_q == DONE;
   assign err = err_q;
   assign prune_count = prune_q;

   always_comb begin
      state_d = state_q;
      cls_d = cls_q;
      s1_d = s1_q;
      s2_d = s2_q;
      j_d = j_q;
      pres_d = pres_q;
      age_d = age_q;
      err_d = err_q;
      prune_d = prune_q;
      mem_en = 1'b0;
      mem_we = 1'b0;
      mem_class = cls_q;
      mem_row = s1_q;
      mem_col = j_q;
      mem_wpresence = !kill;
      mem_wage = kill ? '0 : nage;
      case (state_q)
         IDLE: if (req_valid) begin
            cls_d = req_class;
            s1_d = req_s1;
            s2_d = req_s2;
            j_d = NW'(1);
            err_d = bad;
            prune_d = '0;
            state_d = bad ? DONE : LINK;
         end
         LINK: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            mem_col = s2_q;
            mem_wpresence = 1'b1;
            mem_wage = '0;
`ifdef GAM_SYMMETRIC_EDGE_EN
            state_d = LINK2;
         end
         LINK2: begin
            mem_en = 1'b1;
            mem_we = 1'b1;
            mem_row = s2_q;
            mem_col = s1_q;
            mem_wpresence = 1'b1;
            mem_wage = '0;
`endif
            state_d = RD;
         end
         RD: begin
            mem_en = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            pres_d = mem_rpresence;
            age_d = mem_rage;
            state_d = WR;
         end
         WR: begin
            mem_en = upd;
            mem_we = 1'b1;
            prune_d = upd && kill ? prune_q + 1'b1 : prune_q;
`ifdef GAM_SYMMETRIC_EDGE_EN
            state_d = WR2;
         end
         WR2: begin
            mem_en = upd;
            mem_we = 1'b1;
            mem_row = j_q;
            mem_col = s1_q;
`endif
            state_d = last ? DONE : RD;
            j_d = j_q + 1'b1;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cls_q <= '0;
         s1_q <= '0;
         s2_q <= '0;
         j_q <= '0;
         pres_q <= 1'b0;
         age_q <= '0;
         err_q <= 1'b0;
         prune_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q <= cls_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         j_q <= j_d;
         pres_q <= pres_d;
         age_q <= age_d;
         err_q <= err_d;
         prune_q <= prune_d;
      end
   end
endmodule

// File: tb/tb_gam_edge_age_controller.sv
// tb_gam_edge_age_controller: directed checks of the edge age controller against a behavioural connection RAM.
module tb_gam_edge_age_controller;
   localparam int NW = 4;
   localparam int CW = 3;
   localparam int AW = 8;
`ifdef GAM_SYMMETRIC_EDGE_EN
   localparam int LAT = 43;
   localparam int WSC = 2;
`else
   localparam int LAT = 32;
   localparam int WSC = 1;
`endif
   logic clk = 1'b0, reset_n = 1'b0;
   logic req_valid = 1'b0, req_ready;
   logic [CW-1:0] req_class = '0;
   logic [NW-1:0] req_s1 = '0, req_s2 = '0;
   logic mem_en, mem_we, mem_wpresence;
   logic [CW-1:0] mem_class;
   logic [NW-1:0] mem_row, mem_col;
   logic [AW-1:0] mem_wage;
   logic mem_rpresence = 1'b0;
   logic [AW-1:0] mem_rage = '0;
   logic done, err;
   logic [NW-1:0] prune_count;
   int total = 0, nbad = 0;

   gam_edge_age_controller dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_class(req_class), .req_s1(req_s1), .req_s2(req_s2),
      .mem_en(mem_en), .mem_we(mem_we), .mem_class(mem_class), .mem_row(mem_row), .mem_col(mem_col),
      .mem_wpresence(mem_wpresence), .mem_wage(mem_wage), .mem_rpresence(mem_rpresence), .mem_rage(mem_rage),
      .done(done), .err(err), .prune_count(prune_count)
   );

   always #5 clk = ~clk;

   // connection RAM with one-cycle read latency, plus preload/clear ports owned by the stimulus
   logic mp [0:7][0:15][0:15];
   logic [AW-1:0] ma [0:7][0:15][0:15];
   int en_cnt = 0, wr_cnt = 0;
   logic clr = 1'b0, pl_en = 1'b0, pl_p = 1'b0;
   logic [CW-1:0] pl_c = '0;
   logic [NW-1:0] pl_r = '0, pl_k = '0;
   logic [AW-1:0] pl_a = '0;

   always @(posedge clk) begin
      if (clr) begin
         for (int c = 0; c < 8; c++)
            for (int r = 0; r < 16; r++)
               for (int k = 0; k < 16; k++) begin
                  mp[c][r][k] <= 1'b0;
                  ma[c][r][k] <= '0;
               end
      end else if (pl_en) begin
         mp[pl_c][pl_r][pl_k] <= pl_p;
         ma[pl_c][pl_r][pl_k] <= pl_a;
      end
      if (mem_en) begin
         en_cnt <= en_cnt + 1;
         if (mem_we) begin
            wr_cnt <= wr_cnt + 1;
            mp[mem_class][mem_row][mem_col] <= mem_wpresence;
            ma[mem_class][mem_row][mem_col] <= mem_wage;
         end else begin
            mem_rpresence <= mp[mem_class][mem_row][mem_col];
            mem_rage <= ma[mem_class][mem_row][mem_col];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         nbad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [CW-1:0] c, input logic [NW-1:0] r, input logic [NW-1:0] k,
                          input logic p, input logic [AW-1:0] a);
      @(negedge clk);
      pl_c = c; pl_r = r; pl_k = k; pl_p = p; pl_a = a; pl_en = 1'b1;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic entry(input string tag, input logic [CW-1:0] c, input logic [NW-1:0] r, input logic [NW-1:0] k,
                        input logic p, input logic [AW-1:0] a);
      chk({tag, ".pres"}, mp[c][r][k], p);
      chk({tag, ".age"}, ma[c][r][k], a);
   endtask

   task automatic run_req(input string tag, input logic [CW-1:0] c, input logic [NW-1:0] a, input logic [NW-1:0] b,
                          input int exp_lat, output int ens, output int wrs);
      int lat, en0, wr0;
      @(negedge clk);
      req_valid = 1'b1; req_class = c; req_s1 = a; req_s2 = b;
      chk({tag, ".ready"}, req_ready, 1);
      en0 = en_cnt; wr0 = wr_cnt;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".latency"}, lat, exp_lat);
      chk({tag, ".ready_at_done"}, req_ready, 0);
      ens = en_cnt - en0;
      wrs = wr_cnt - wr0;
      @(negedge clk);
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".ready_after"}, req_ready, 1);
   endtask

   initial begin
      int ens, wrs;
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      chk("rst.ready", req_ready, 1);
      chk("rst.done", done, 0);
      chk("rst.mem_en", mem_en, 0);
      chk("rst.err", err, 0);
      chk("rst.prune", prune_count, 0);
      reset_n = 1'b1;

      run_req("s1", 3'd1, 4'd3, 4'd5, LAT, ens, wrs);
      chk("s1.writes", wrs, WSC);
      chk("s1.en", ens, WSC + 10);
      chk("s1.err", err, 0);
      chk("s1.prune", prune_count, 0);
      entry("s1.link", 3'd1, 4'd3, 4'd5, 1'b1, 8'd0);
`ifdef GAM_SYMMETRIC_EDGE_EN
      entry("s1.mirror", 3'd1, 4'd5, 4'd3, 1'b1, 8'd0);
`endif

      preload(3'd2, 4'd4, 4'd7, 1'b1, 8'd1);
      preload(3'd2, 4'd4, 4'd8, 1'b1, 8'd2);
      run_req("s2", 3'd2, 4'd4, 4'd1, LAT, ens, wrs);
      chk("s2.writes", wrs, 3 * WSC);
      chk("s2.err", err, 0);
      chk("s2.prune", prune_count, 1);
      entry("s2.link", 3'd2, 4'd4, 4'd1, 1'b1, 8'd0);
      entry("s2.age", 3'd2, 4'd4, 4'd7, 1'b1, 8'd2);
      entry("s2.pruned", 3'd2, 4'd4, 4'd8, 1'b0, 8'd0);
`ifdef GAM_SYMMETRIC_EDGE_EN
      entry("s6.age_mirror", 3'd2, 4'd7, 4'd4, 1'b1, 8'd2);
      entry("s6.prune_mirror", 3'd2, 4'd8, 4'd4, 1'b0, 8'd0);
`endif

      run_req("s4.same", 3'd1, 4'd4, 4'd4, 1, ens, wrs);
      chk("s4.same.en", ens, 0);
      chk("s4.same.err", err, 1);
      chk("s4.same.prune", prune_count, 0);
      run_req("s4.class0", 3'd0, 4'd1, 4'd2, 1, ens, wrs);
      chk("s4.class0.en", ens, 0);
      chk("s4.class0.err", err, 1);
      run_req("s4.class5", 3'd5, 4'd1, 4'd2, 1, ens, wrs);
      chk("s4.class5.en", ens, 0);
      chk("s4.class5.err", err, 1);
      run_req("s4.node11", 3'd1, 4'd11, 4'd2, 1, ens, wrs);
      chk("s4.node11.en", ens, 0);
      chk("s4.node11.err", err, 1);
      run_req("s4.node0", 3'd1, 4'd2, 4'd0, 1, ens, wrs);
      chk("s4.node0.en", ens, 0);
      chk("s4.node0.err", err, 1);

      preload(3'd1, 4'd2, 4'd6, 1'b1, 8'd5);
      run_req("s3", 3'd1, 4'd2, 4'd6, LAT, ens, wrs);
      chk("s3.writes", wrs, WSC);
      chk("s3.err", err, 0);
      chk("s3.prune", prune_count, 0);
      entry("s3.link", 3'd1, 4'd2, 4'd6, 1'b1, 8'd0);

      @(negedge clk);
      req_valid = 1'b1; req_class = 3'd4; req_s1 = 4'd1; req_s2 = 4'd2;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (14) @(negedge clk);
      chk("s5.busy", req_ready, 0);
      reset_n = 1'b0;
      #1;
      chk("s5.ready", req_ready, 1);
      chk("s5.done", done, 0);
      chk("s5.mem_en", mem_en, 0);
      chk("s5.err", err, 0);
      chk("s5.prune", prune_count, 0);
      @(negedge clk);
      reset_n = 1'b1;

      preload(3'd3, 4'd5, 4'd2, 1'b1, 8'd0);
      preload(3'd3, 4'd5, 4'd9, 1'b1, 8'd255);
      preload(3'd3, 4'd5, 4'd10, 1'b1, 8'd7);
      run_req("s5.next", 3'd3, 4'd5, 4'd10, LAT, ens, wrs);
      chk("s5.next.writes", wrs, 3 * WSC);
      chk("s5.next.err", err, 0);
      chk("s5.next.prune", prune_count, 1);
      entry("s5.next.link", 3'd3, 4'd5, 4'd10, 1'b1, 8'd0);
      entry("s5.next.age", 3'd3, 4'd5, 4'd2, 1'b1, 8'd1);
      entry("s5.next.sat", 3'd3, 4'd5, 4'd9, 1'b0, 8'd0);

      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end
endmodule
